// File: rtl/uart_streamer_pkg.sv
// uart_streamer_pkg: shared states and defaults for the program streamer.
// Optional checksum stage guarded by UART_STREAMER_CKSUM_EN.
package uart_streamer_pkg;

  localparam logic [13:0] DEF_DATA_CSR_ADDR = 14'h0000;
  localparam logic [13:0] DEF_THRU_CSR_ADDR = 14'h0002;
  localparam logic [7:0]  DEF_TRAILER       = 8'hBA;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_THRU,
    ST_FETCH,
    ST_LATCH,
    ST_WRITE,
    ST_WAIT_TX,
    ST_GAP,
`ifdef UART_STREAMER_CKSUM_EN
    ST_CKSUM,
`endif
    ST_TRAIL,
    ST_FIN
  } st_e;

endpackage

// File: rtl/uart_streamer_gap_cnt.sv
// uart_streamer_gap_cnt: loadable down-counter, flags its last count.
// Used for inter-byte gaps; also usable as a tx timeout.
module uart_streamer_gap_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // load wins over decrement; saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q <= W'(1));

endmodule

// File: rtl/uart_program_streamer.sv
// uart_program_streamer: streams a memory image into an op_uart CSR port.
// UART_STREAMER_CKSUM_EN adds a two's-complement checksum byte.
module uart_program_streamer
  import uart_streamer_pkg::*;
#(
  parameter int                 DEPTH         = 4096,
  parameter int                 AW            = $clog2(DEPTH),
  parameter int                 CSR_AW        = 14,
  parameter logic [CSR_AW-1:0]  DATA_CSR_ADDR = CSR_AW'(DEF_DATA_CSR_ADDR),
  parameter logic [CSR_AW-1:0]  THRU_CSR_ADDR = CSR_AW'(DEF_THRU_CSR_ADDR),
  parameter logic [7:0]         TRAILER       = DEF_TRAILER,
  parameter int                 GAP_CYCLES    = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [AW:0]       len,
  input  logic              abort,
  output logic              mem_rd,
  output logic [AW-1:0]     mem_addr,
  input  logic [7:0]        mem_data,
  output logic [CSR_AW-1:0] csr_a,
  output logic              csr_we,
  output logic [31:0]       csr_di,
  input  logic              tx_irq,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       byte_cnt
);

`ifdef UART_STREAMER_CKSUM_EN
  localparam st_e END_ST = ST_CKSUM;
`else
  localparam st_e END_ST = ST_TRAIL;
`endif

  st_e               state_q, state_d;
  logic [AW:0]       len_q, len_d;
  logic [AW:0]       idx_q, idx_d;
  logic [AW:0]       idx_inc;
  logic [CSR_AW-1:0] csr_a_q, csr_a_d;
  logic [31:0]       csr_di_q, csr_di_d;
  logic              sent_q, sent_d;
  logic              tail_st;
  logic              gap_load, gap_dec, gap_last;
`ifdef UART_STREAMER_CKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  assign idx_inc = idx_q + 1'b1;

`ifdef UART_STREAMER_CKSUM_EN
  assign tail_st = (state_q == ST_TRAIL) || (state_q == ST_CKSUM);
`else
  assign tail_st = (state_q == ST_TRAIL);
`endif

  assign gap_load = (state_q == ST_WAIT_TX) && tx_irq;
  assign gap_dec  = (state_q == ST_GAP);

  uart_streamer_gap_cnt #(
    .W (8)
  ) u_gap (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .load_i     (gap_load),
    .load_val_i (8'(GAP_CYCLES)),
    .dec_i      (gap_dec),
    .last_o     (gap_last)
  );

  // state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; abort overrides every state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_THRU;
      ST_THRU:  state_d = (len_q == '0) ? END_ST : ST_FETCH;
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (tx_irq) begin
          if (GAP_CYCLES > 0)      state_d = ST_GAP;
          else if (idx_inc < len_q) state_d = ST_FETCH;
          else                     state_d = END_ST;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          state_d = (idx_q < len_q) ? ST_FETCH : END_ST;
        end
      end
`ifdef UART_STREAMER_CKSUM_EN
      ST_CKSUM: if (sent_q && tx_irq) state_d = ST_TRAIL;
`endif
      ST_TRAIL: if (sent_q && tx_irq) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // outputs; csr_we is killed combinationally by abort
  always_comb begin
    csr_we = 1'b0;
    mem_rd = 1'b0;
    done   = 1'b0;
    busy   = (state_q != ST_IDLE) && (state_q != ST_FIN);
    unique case (state_q)
      ST_THRU, ST_WRITE: csr_we = !abort;
      ST_FETCH:          mem_rd = 1'b1;
      ST_FIN:            done   = 1'b1;
      default:           csr_we = tail_st && !sent_q && !abort;
    endcase
  end

  // datapath next values, loaded on state entry
  always_comb begin
    len_d    = len_q;
    idx_d    = idx_q;
    csr_a_d  = csr_a_q;
    csr_di_d = csr_di_q;
    sent_d   = tail_st && (state_d == state_q);
`ifdef UART_STREAMER_CKSUM_EN
    cksum_d  = cksum_q;
`endif
    if (state_d != state_q) begin
      unique case (state_d)
        ST_THRU: begin
          len_d    = len;
          idx_d    = '0;
          csr_a_d  = THRU_CSR_ADDR;
          csr_di_d = '0;
`ifdef UART_STREAMER_CKSUM_EN
          cksum_d  = '0;
`endif
        end
        ST_WRITE: begin
          csr_a_d  = DATA_CSR_ADDR;
          csr_di_d = {24'h0, mem_data};
`ifdef UART_STREAMER_CKSUM_EN
          cksum_d  = cksum_q + mem_data;
`endif
        end
`ifdef UART_STREAMER_CKSUM_EN
        ST_CKSUM: begin
          csr_a_d  = DATA_CSR_ADDR;
          csr_di_d = {24'h0, 8'h00 - cksum_q};
        end
`endif
        ST_TRAIL: begin
          csr_a_d  = DATA_CSR_ADDR;
          csr_di_d = {24'h0, TRAILER};
        end
        default: ;
      endcase
    end
    if (state_q == ST_WAIT_TX && tx_irq && state_d != ST_IDLE) begin
      idx_d = idx_inc;
    end
  end

  // datapath registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      len_q    <= '0;
      idx_q    <= '0;
      csr_a_q  <= '0;
      csr_di_q <= '0;
      sent_q   <= 1'b0;
`ifdef UART_STREAMER_CKSUM_EN
      cksum_q  <= '0;
`endif
    end else begin
      len_q    <= len_d;
      idx_q    <= idx_d;
      csr_a_q  <= csr_a_d;
      csr_di_q <= csr_di_d;
      sent_q   <= sent_d;
`ifdef UART_STREAMER_CKSUM_EN
      cksum_q  <= cksum_d;
`endif
    end
  end

  assign mem_addr = idx_q[AW-1:0];
  assign byte_cnt = idx_q;
  assign csr_a    = csr_a_q;
  assign csr_di   = csr_di_q;

endmodule

// File: tb/tb_uart_program_streamer.sv
// tb_uart_program_streamer: scoreboard bench, two DUTs (gap 0 and gap 5).
// A behavioural memory and UART answer each DUT on the falling edge.
`timescale 1ns/1ps
module tb_uart_program_streamer;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam logic [13:0] A_DATA = 14'h0000;
  localparam logic [13:0] A_THRU = 14'h0002;

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
    bit          img;
    bit          thru;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_s   [2] = '{1'b0, 1'b0};
  logic [AW:0] len_s     [2] = '{'0, '0};
  logic        abort_s   [2] = '{1'b0, 1'b0};
  logic        irq_stray [2] = '{1'b0, 1'b0};
  logic        irq_resp  [2] = '{1'b0, 1'b0};
  logic [7:0]  mem_data_s[2] = '{8'hEE, 8'hEE};

  logic          mem_rd_w  [2];
  logic [AW-1:0] mem_addr_w[2];
  logic [13:0]   csr_a_w   [2];
  logic          csr_we_w  [2];
  logic [31:0]   csr_di_w  [2];
  logic          busy_w    [2];
  logic          done_w    [2];
  logic [AW:0]   byte_cnt_w[2];

  logic [7:0] mem [DEPTH];
  wr_t exp_q [2][$];

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int done_cnt[2]  = '{0, 0};
  int rd_cnt[2]    = '{0, 0};
  int wr_cnt[2]    = '{0, 0};
  int tx_cnt[2]    = '{0, 0};
  int irq_cyc[2]   = '{0, 0};
  int thru_cyc[2]  = '{0, 0};
  int start_cyc[2] = '{0, 0};
  bit irq_arm[2]    = '{0, 0};
  bit aft_thru[2]   = '{0, 0};
  bit rd_pend[2]    = '{0, 0};
  logic [AW-1:0] rd_addr[2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    uart_program_streamer #(
      .GAP_CYCLES (k == 1 ? 5 : 0)
    ) dut (
      .sys_clk  (clk),
      .sys_rst  (rst),
      .start    (start_s[k]),
      .len      (len_s[k]),
      .abort    (abort_s[k]),
      .mem_rd   (mem_rd_w[k]),
      .mem_addr (mem_addr_w[k]),
      .mem_data (mem_data_s[k]),
      .csr_a    (csr_a_w[k]),
      .csr_we   (csr_we_w[k]),
      .csr_di   (csr_di_w[k]),
      .tx_irq   (irq_resp[k] | irq_stray[k]),
      .busy     (busy_w[k]),
      .done     (done_w[k]),
      .byte_cnt (byte_cnt_w[k])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory and UART models plus write scoreboard, all on the falling edge
  always @(negedge clk) begin
    wr_t e;
    for (int k = 0; k < 2; k++) begin
      irq_resp[k] = 1'b0;
      mem_data_s[k] = rd_pend[k] ? mem[rd_addr[k]] : 8'hEE;
      rd_pend[k] = mem_rd_w[k];
      rd_addr[k] = mem_addr_w[k];
      if (mem_rd_w[k]) rd_cnt[k]++;
      if (tx_cnt[k] > 0) begin
        tx_cnt[k]--;
        if (tx_cnt[k] == 0) begin
          irq_resp[k] = 1'b1;
          irq_cyc[k]  = cyc;
          irq_arm[k]  = 1'b1;
        end
      end
      if (csr_we_w[k]) begin
        wr_cnt[k]++;
        chk("wr_expected", 32'(exp_q[k].size() != 0), 32'd1);
        if (exp_q[k].size() != 0) begin
          e = exp_q[k].pop_front();
          chk("wr_addr", 32'(csr_a_w[k]), 32'(e.a));
          chk("wr_data", csr_di_w[k], e.d);
          if (e.thru) begin
            chk("start_to_thru", 32'(cyc - start_cyc[k]), 32'd1);
            thru_cyc[k] = cyc;
          end
          if (e.img && irq_arm[k])
            chk("irq_to_wr", 32'(cyc - irq_cyc[k]), (k == 1) ? 32'd8 : 32'd3);
          if (e.img && aft_thru[k])
            chk("thru_to_first", 32'(cyc - thru_cyc[k]), 32'd3);
          aft_thru[k] = e.thru;
        end
        irq_arm[k] = 1'b0;
        if (csr_a_w[k] == A_DATA) tx_cnt[k] = 10;
      end
      if (done_w[k]) begin
        done_cnt[k]++;
        chk("done_lat", 32'(cyc - irq_cyc[k]), 32'd1);
        chk("busy_at_done", 32'(busy_w[k]), 32'd0);
      end
    end
  end

  task automatic push(input int k, input logic [13:0] a, input logic [7:0] d,
                      input bit img, input bit thru);
    wr_t e;
    e.a = a;
    e.d = {24'h0, d};
    e.img = img;
    e.thru = thru;
    exp_q[k].push_back(e);
  endtask

  task automatic run(input int k, input int n, input bit stray);
    logic [7:0] s;
    int d0;
    int r0;
    s = 8'h00;
    push(k, A_THRU, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      push(k, A_DATA, mem[i], 1'b1, 1'b0);
      s = s + mem[i];
    end
`ifdef UART_STREAMER_CKSUM_EN
    push(k, A_DATA, 8'h00 - s, 1'b0, 1'b0);
`endif
    push(k, A_DATA, 8'hBA, 1'b0, 1'b0);
    d0 = done_cnt[k];
    r0 = rd_cnt[k];
    @(negedge clk);
    start_s[k] = 1'b1;
    len_s[k] = (AW+1)'(n);
    start_cyc[k] = cyc;
    @(negedge clk);
    start_s[k] = 1'b0;
    len_s[k] = (AW+1)'(1);
    if (stray) begin
      start_s[k] = 1'b1;
      @(negedge clk);
      start_s[k] = 1'b0;
      irq_stray[k] = 1'b1;
      @(negedge clk);
      irq_stray[k] = 1'b0;
    end
    for (int t = 0; t < 3000 && done_cnt[k] == d0; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("done_once", 32'(done_cnt[k] - d0), 32'd1);
    chk("byte_cnt", 32'(byte_cnt_w[k]), 32'(n));
    chk("rd_cnt", 32'(rd_cnt[k] - r0), 32'(n));
    chk("queue_empty", 32'(exp_q[k].size()), 32'd0);
    chk("busy_idle", 32'(busy_w[k]), 32'd0);
  endtask

  initial begin
    int w0;
    int d0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 32'(busy_w[k]), 32'd0);
      chk("rst_done", 32'(done_w[k]), 32'd0);
      chk("rst_we", 32'(csr_we_w[k]), 32'd0);
      chk("rst_rd", 32'(mem_rd_w[k]), 32'd0);
      chk("rst_bcnt", 32'(byte_cnt_w[k]), 32'd0);
      chk("rst_csr_a", 32'(csr_a_w[k]), 32'd0);
      chk("rst_csr_di", csr_di_w[k], 32'd0);
      chk("rst_maddr", 32'(mem_addr_w[k]), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    run(0, 3, 1'b0);
    run(0, 0, 1'b0);
    run(0, 3, 1'b1);

    irq_stray[0] = 1'b1;
    @(negedge clk);
    irq_stray[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_irq_busy", 32'(busy_w[0]), 32'd0);
    chk("idle_irq_bcnt", 32'(byte_cnt_w[0]), 32'd3);

    run(1, 3, 1'b0);

    mem[0] = 8'hA1;
    mem[1] = 8'hB2;
    mem[2] = 8'hC3;
    mem[3] = 8'hD4;
    push(0, A_THRU, 8'h00, 1'b0, 1'b1);
    push(0, A_DATA, 8'hA1, 1'b1, 1'b0);
    push(0, A_DATA, 8'hB2, 1'b1, 1'b0);
    w0 = wr_cnt[0];
    d0 = done_cnt[0];
    @(negedge clk);
    start_s[0] = 1'b1;
    len_s[0] = (AW+1)'(4);
    start_cyc[0] = cyc;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int t = 0; t < 500 && wr_cnt[0] < w0 + 3; t++) @(negedge clk);
    chk("abort_reach", 32'(wr_cnt[0] - w0), 32'd3);
    @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    repeat (30) @(negedge clk);
    chk("abort_wrs", 32'(wr_cnt[0] - w0), 32'd3);
    chk("abort_done", 32'(done_cnt[0] - d0), 32'd0);
    chk("abort_bcnt", 32'(byte_cnt_w[0]), 32'd1);
    chk("abort_queue", 32'(exp_q[0].size()), 32'd0);

    run(0, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
